bus_arbiter: RTL and testbench

Two-master arbiter that shares the single system bus between the hart (rv_core) and the debug module's system-bus-access port (dm). It accepts one transaction at a time and drives it onto the bus. It waits for the slave response, with a timeout, and returns read data and an error flag to the winning requester. It sits between the two masters and the memory/gpio/hex/exti slaves.

---
 rtl/bus_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares the single system bus between the hart and the debug module's
// system-bus-access port. One transaction is in flight at a time. The winner's
// command is latched and held on the bus until the slave answers with
// bus_ready, or until the BUSY timeout expires. The response (read data plus
// error flag) is then returned to the winner as a one-cycle ack.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   h_req/h_we/h_addr/h_wdata/h_be     hart request
//   h_ack/h_err/h_rdata                hart response (err/rdata valid with ack)
//   d_req/d_we/d_addr/d_wdata/d_be     debug request
//   d_ack/d_err/d_rdata                debug response
//   dbg_lock                           blocks new hart grants while high
//   bus_rd/bus_wr/bus_addr/bus_wdata/bus_be   bus command (held during BUSY)
//   bus_rdata/bus_ready                slave response
//   busy                               transaction in flight (BUSY or RESP)
//   owner                              current/last grant: 0 hart, 1 debug
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int ByteSize      = 8,
    parameter int TimeoutCycles = 255,
    parameter int DebugPriority = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             h_req,
    input  logic                             h_we,
    input  logic [AddressWidth-1:0]          h_addr,
    input  logic [DataWidth-1:0]             h_wdata,
    input  logic [DataWidth/ByteSize-1:0]    h_be,
    output logic                             h_ack,
    output logic                             h_err,
    output logic [DataWidth-1:0]             h_rdata,
    input  logic                             d_req,
    input  logic                             d_we,
    input  logic [AddressWidth-1:0]          d_addr,
    input  logic [DataWidth-1:0]             d_wdata,
    input  logic [DataWidth/ByteSize-1:0]    d_be,
    output logic                             d_ack,
    output logic                             d_err,
    output logic [DataWidth-1:0]             d_rdata,
    input  logic                             dbg_lock,
    output logic                             bus_rd,
    output logic                             bus_wr,
    output logic [AddressWidth-1:0]          bus_addr,
    output logic [DataWidth-1:0]             bus_wdata,
    output logic [DataWidth/ByteSize-1:0]    bus_be,
    input  logic [DataWidth-1:0]             bus_rdata,
    input  logic                             bus_ready,
    output logic                             busy,
    output logic                             owner
);

    localparam int BeW  = DataWidth / ByteSize;
    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_we;
    logic [AddressWidth-1:0] r_addr;
    logic [DataWidth-1:0]    r_wdata;
    logic [BeW-1:0]          r_be;
    logic                    r_owner;
    logic                    r_rr_ptr;   // 0: hart preferred on contention
    logic [CntW-1:0]         r_cnt;
    logic                    r_bus_rd;
    logic                    r_bus_wr;
    logic                    r_busy;
    logic                    r_h_ack;
    logic                    r_h_err;
    logic [DataWidth-1:0]    r_h_rdata;
    logic                    r_d_ack;
    logic                    r_d_err;
    logic [DataWidth-1:0]    r_d_rdata;

    logic                    w_h_elig;
    logic                    w_d_elig;
    logic                    w_grant;
    logic                    w_winner;
    logic                    w_sel_we;
    logic [AddressWidth-1:0] w_sel_addr;
    logic [DataWidth-1:0]    w_sel_wdata;
    logic [BeW-1:0]          w_sel_be;
    logic                    w_done;
    logic                    w_timeout;
    logic [DataWidth-1:0]    w_resp_rdata;

    // Winner selection and request mux for the IDLE grant decision.
    always_comb begin
        w_h_elig = h_req & ~dbg_lock;
        w_d_elig = d_req;
        w_grant  = w_h_elig | w_d_elig;
        w_winner = 1'b0;
        if (w_h_elig && w_d_elig) begin
            w_winner = (DebugPriority != 0) ? 1'b1 : r_rr_ptr;
        end else if (w_d_elig) begin
            w_winner = 1'b1;
        end else begin
            w_winner = 1'b0;
        end
        if (w_winner) begin
            w_sel_we    = d_we;
            w_sel_addr  = d_addr;
            w_sel_wdata = d_wdata;
            w_sel_be    = d_be;
        end else begin
            w_sel_we    = h_we;
            w_sel_addr  = h_addr;
            w_sel_wdata = h_wdata;
            w_sel_be    = h_be;
        end
    end

    // BUSY completion: ready beats the timeout when both land on one cycle.
    always_comb begin
        w_timeout    = (r_cnt == CntLast);
        w_done       = bus_ready | w_timeout;
        w_resp_rdata = {DataWidth{1'b0}};
        if (bus_ready && !r_we) begin
            w_resp_rdata = bus_rdata;
        end else begin
            w_resp_rdata = {DataWidth{1'b0}};
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_addr    <= {AddressWidth{1'b0}};
            r_wdata   <= {DataWidth{1'b0}};
            r_be      <= {BeW{1'b0}};
            r_owner   <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_cnt     <= {CntW{1'b0}};
            r_bus_rd  <= 1'b0;
            r_bus_wr  <= 1'b0;
            r_busy    <= 1'b0;
            r_h_ack   <= 1'b0;
            r_h_err   <= 1'b0;
            r_h_rdata <= {DataWidth{1'b0}};
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
            r_d_rdata <= {DataWidth{1'b0}};
        end else begin
            // Acks are single-cycle pulses; rdata/err are left holding.
            r_h_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_we     <= w_sel_we;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        r_be     <= w_sel_be;
                        r_owner  <= w_winner;
                        r_rr_ptr <= ~w_winner;
                        r_cnt    <= {CntW{1'b0}};
                        r_bus_rd <= ~w_sel_we;
                        r_bus_wr <= w_sel_we;
                        r_busy   <= 1'b1;
                        r_state  <= ST_BUSY;
                    end else begin
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_bus_rd <= 1'b0;
                        r_bus_wr <= 1'b0;
                        r_state  <= ST_RESP;
                        if (r_owner) begin
                            r_d_ack   <= 1'b1;
                            r_d_err   <= ~bus_ready;
                            r_d_rdata <= w_resp_rdata;
                        end else begin
                            r_h_ack   <= 1'b1;
                            r_h_err   <= ~bus_ready;
                            r_h_rdata <= w_resp_rdata;
                        end
                    end else begin
                        r_cnt   <= r_cnt + CntW'(1);
                        r_state <= ST_BUSY;
                    end
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_bus_rd <= 1'b0;
                    r_bus_wr <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign h_ack     = r_h_ack;
    assign h_err     = r_h_err;
    assign h_rdata   = r_h_rdata;
    assign d_ack     = r_d_ack;
    assign d_err     = r_d_err;
    assign d_rdata   = r_d_rdata;
    assign bus_rd    = r_bus_rd;
    assign bus_wr    = r_bus_wr;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_be    = r_be;
    assign busy      = r_busy;
    assign owner     = r_owner;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter. Two instances share all inputs: dut_p uses
// debug priority, dut_r uses round-robin; both use a 4-cycle timeout. Every
// transaction has the same latency regardless of winner, so one shared slave
// response drives both; only grant order differs.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        h_req, h_we, d_req, d_we, dbg_lock, bus_ready;
    logic [31:0] h_addr, h_wdata, d_addr, d_wdata, bus_rdata;
    logic [3:0]  h_be, d_be;

    logic        p_h_ack, p_h_err, p_d_ack, p_d_err, p_bus_rd, p_bus_wr, p_busy, p_owner;
    logic [31:0] p_h_rdata, p_d_rdata, p_bus_addr, p_bus_wdata;
    logic [3:0]  p_bus_be;
    logic        q_h_ack, q_h_err, q_d_ack, q_d_err, q_bus_rd, q_bus_wr, q_busy, q_owner;
    logic [31:0] q_h_rdata, q_d_rdata, q_bus_addr, q_bus_wdata;
    logic [3:0]  q_bus_be;

    int n_vec;
    int n_err;

    bus_arbiter #(.TimeoutCycles(4), .DebugPriority(1)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_be(h_be),
        .h_ack(p_h_ack), .h_err(p_h_err), .h_rdata(p_h_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(p_d_ack), .d_err(p_d_err), .d_rdata(p_d_rdata),
        .dbg_lock(dbg_lock),
        .bus_rd(p_bus_rd), .bus_wr(p_bus_wr), .bus_addr(p_bus_addr),
        .bus_wdata(p_bus_wdata), .bus_be(p_bus_be),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .busy(p_busy), .owner(p_owner)
    );

    bus_arbiter #(.TimeoutCycles(4), .DebugPriority(0)) dut_r (
        .clk(clk), .rst_n(rst_n),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_be(h_be),
        .h_ack(q_h_ack), .h_err(q_h_err), .h_rdata(q_h_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(q_d_ack), .d_err(q_d_err), .d_rdata(q_d_rdata),
        .dbg_lock(dbg_lock),
        .bus_rd(q_bus_rd), .bus_wr(q_bus_wr), .bus_addr(q_bus_addr),
        .bus_wdata(q_bus_wdata), .bus_be(q_bus_be),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .busy(q_busy), .owner(q_owner)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every vector and reports miscompares.
    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        logic [1:0] rr_exp [4];
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        h_req = 1'b0; h_we = 1'b0; h_addr = 32'h0; h_wdata = 32'h0; h_be = 4'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        dbg_lock = 1'b0; bus_ready = 1'b0; bus_rdata = 32'h0;

        // Reset state
        #3;
        chk_eq("rst_bus_rd", {31'd0, p_bus_rd}, 32'd0);
        chk_eq("rst_busy",   {31'd0, p_busy},   32'd0);
        chk_eq("rst_owner",  {31'd0, p_owner},  32'd0);
        chk_eq("rst_h_ack",  {31'd0, p_h_ack},  32'd0);
        chk_eq("rst_addr",   p_bus_addr,        32'd0);
        #9 rst_n = 1'b1;

        // Hart read, slave ready in the second BUSY cycle
        h_req = 1'b1; h_we = 1'b0; h_addr = 32'h0000_0010; h_be = 4'hF;
        tick();
        chk_eq("t1_rd_c0", {31'd0, p_bus_rd}, 32'd1);
        chk_eq("t1_addr",  p_bus_addr,        32'h0000_0010);
        chk_eq("t1_busy",  {31'd0, p_busy},   32'd1);
        chk_eq("t1_owner", {31'd0, p_owner},  32'd0);
        tick();
        chk_eq("t1_rd_c1", {31'd0, p_bus_rd}, 32'd1);
        chk_eq("t1_noack", {31'd0, p_h_ack},  32'd0);
        bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick();
        chk_eq("t1_ack",    {31'd0, p_h_ack},  32'd1);
        chk_eq("t1_rdata",  p_h_rdata,         32'hDEAD_BEEF);
        chk_eq("t1_err",    {31'd0, p_h_err},  32'd0);
        chk_eq("t1_d_ack",  {31'd0, p_d_ack},  32'd0);
        chk_eq("t1_rd_off", {31'd0, p_bus_rd}, 32'd0);
        chk_eq("t1_resp_busy", {31'd0, p_busy}, 32'd1);
        h_req = 1'b0; bus_ready = 1'b0;
        tick();
        chk_eq("t1_ack_pulse", {31'd0, p_h_ack}, 32'd0);
        chk_eq("t1_idle_busy", {31'd0, p_busy},  32'd0);
        chk_eq("t1_hold",      p_h_rdata,        32'hDEAD_BEEF);

        // Contention with debug priority: debug read, then hart write
        h_req = 1'b1; h_we = 1'b1; h_addr = 32'h0000_0020; h_wdata = 32'h1111_1111; h_be = 4'hF;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0030; d_be = 4'hF;
        tick();
        chk_eq("t2_owner_d", {31'd0, p_owner}, 32'd1);
        chk_eq("t2_addr_d",  p_bus_addr,       32'h0000_0030);
        bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        chk_eq("t2_d_ack",   {31'd0, p_d_ack}, 32'd1);
        chk_eq("t2_d_rdata", p_d_rdata,        32'hCAFE_F00D);
        chk_eq("t2_h_noack", {31'd0, p_h_ack}, 32'd0);
        d_req = 1'b0; bus_ready = 1'b0;
        tick();
        tick();
        chk_eq("t2_owner_h", {31'd0, p_owner},  32'd0);
        chk_eq("t2_wr",      {31'd0, p_bus_wr}, 32'd1);
        chk_eq("t2_rd_low",  {31'd0, p_bus_rd}, 32'd0);
        chk_eq("t2_wdata",   p_bus_wdata,       32'h1111_1111);
        bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
        tick();
        chk_eq("t2_h_ack",   {31'd0, p_h_ack}, 32'd1);
        chk_eq("t2_wr_rdat", p_h_rdata,        32'd0);
        h_req = 1'b0; bus_ready = 1'b0;
        tick();

        // Debug write timeout, request dropped mid-transaction
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'hF000_0000; d_wdata = 32'hA5A5_A5A5; d_be = 4'h3;
        tick();
        chk_eq("t3_be", {28'd0, p_bus_be}, 32'h3);
        d_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_eq($sformatf("t3_wr_c%0d", i), {31'd0, p_bus_wr}, 32'd1);
            if (i < 3) tick();
        end
        tick();
        chk_eq("t3_wr_off",  {31'd0, p_bus_wr}, 32'd0);
        chk_eq("t3_d_ack",   {31'd0, p_d_ack},  32'd1);
        chk_eq("t3_d_err",   {31'd0, p_d_err},  32'd1);
        chk_eq("t3_d_rdata", p_d_rdata,         32'd0);
        tick();
        chk_eq("t3_err_hold", {31'd0, p_d_err}, 32'd1);

        // Ready coincides with the last counter value: ready wins
        h_req = 1'b1; h_we = 1'b0; h_addr = 32'h0000_0040;
        tick();
        tick();
        tick();
        tick();
        chk_eq("t4_rd_c3", {31'd0, p_bus_rd}, 32'd1);
        bus_ready = 1'b1; bus_rdata = 32'h0BAD_C0DE;
        tick();
        chk_eq("t4_ack",     {31'd0, p_h_ack}, 32'd1);
        chk_eq("t4_err",     {31'd0, p_h_err}, 32'd0);
        chk_eq("t4_rdata",   p_h_rdata,        32'h0BAD_C0DE);
        chk_eq("t4_d_err_k", {31'd0, p_d_err}, 32'd1);
        h_req = 1'b0; bus_ready = 1'b0;
        tick();

        // dbg_lock holds off the hart while debug runs back-to-back
        dbg_lock = 1'b1;
        h_req = 1'b1; h_we = 1'b0; h_addr = 32'h0000_0050;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0060;
        bus_ready = 1'b1; bus_rdata = 32'h0000_0077;
        tick();
        chk_eq("t5_own0", {31'd0, q_owner}, 32'd1);
        tick();
        chk_eq("t5_dack0", {31'd0, q_d_ack}, 32'd1);
        tick();
        chk_eq("t5_idle_busy", {31'd0, q_busy}, 32'd0);
        tick();
        chk_eq("t5_own1",  {31'd0, q_owner}, 32'd1);
        chk_eq("t5_addr1", q_bus_addr,       32'h0000_0060);
        tick();
        chk_eq("t5_dack1", {31'd0, q_d_ack}, 32'd1);
        chk_eq("t5_hnack", {31'd0, q_h_ack}, 32'd0);
        d_req = 1'b0; dbg_lock = 1'b0;
        tick();
        tick();
        chk_eq("t5_own_h",  {31'd0, q_owner},  32'd0);
        chk_eq("t5_rd_h",   {31'd0, q_bus_rd}, 32'd1);
        chk_eq("t5_addr_h", q_bus_addr,        32'h0000_0050);
        tick();
        chk_eq("t5_h_ack",  {31'd0, q_h_ack},  32'd1);
        chk_eq("t5_h_rdat", q_h_rdata,         32'h0000_0077);
        h_req = 1'b0; bus_ready = 1'b0;
        tick();

        // Asynchronous reset in BUSY
        h_req = 1'b1; h_we = 1'b0; h_addr = 32'h0000_0070;
        tick();
        chk_eq("t6_rd_pre", {31'd0, p_bus_rd}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("t6_rd_rst",   {31'd0, p_bus_rd}, 32'd0);
        chk_eq("t6_busy_rst", {31'd0, p_busy},   32'd0);
        chk_eq("t6_rdat_rst", p_h_rdata,         32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk_eq("t6_noack", {31'd0, p_h_ack},  32'd0);
        chk_eq("t6_regrant", {31'd0, p_bus_rd}, 32'd1);
        bus_ready = 1'b1; bus_rdata = 32'h5555_AAAA;
        tick();
        chk_eq("t6_ack",   {31'd0, p_h_ack}, 32'd1);
        chk_eq("t6_rdata", p_h_rdata,        32'h5555_AAAA);
        h_req = 1'b0; bus_ready = 1'b0;
        tick();

        // Round-robin from reset with both masters requesting continuously
        rst_n = 1'b0;
        h_req = 1'b1; h_we = 1'b0; h_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
        bus_ready = 1'b1; bus_rdata = 32'h0000_0001;
        #3 rst_n = 1'b1;
        rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd0; rr_exp[3] = 2'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_eq($sformatf("t7_rr_own%0d", i), {31'd0, q_owner}, {30'd0, rr_exp[i]});
            chk_eq($sformatf("t7_rr_addr%0d", i), q_bus_addr,
                   (rr_exp[i] == 2'd1) ? 32'h0000_0200 : 32'h0000_0100);
            chk_eq($sformatf("t7_pri_own%0d", i), {31'd0, p_owner}, 32'd1);
            tick();
            tick();
        end
        h_req = 1'b0; d_req = 1'b0; bus_ready = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
